// File: rtl/sampler_tracker_pkg.sv
// Shared definitions for the sampler tracker readout logic: FSM state
// encoding, packed output word layout and the word packing helper.
package sampler_tracker_pkg;

  // Readout FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETADDR = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SEND    = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Output word layout: {status[1:0], trace[29:0]}.
  localparam int WORD_WIDTH  = 32;
  localparam int STATUS_MSB  = 31;
  localparam int STATUS_LSB  = 30;
  localparam int TRACE_WIDTH = 30;

  // Places the eviction status above the (already zero-extended) trace value.
  function automatic logic [WORD_WIDTH-1:0] pack_word(
    input logic [1:0]             status,
    input logic [TRACE_WIDTH-1:0] trace
  );
    logic [WORD_WIDTH-1:0] word;
    word                        = '0;
    word[STATUS_MSB:STATUS_LSB] = status;
    word[TRACE_WIDTH-1:0]       = trace;
    return word;
  endfunction

endpackage

// File: rtl/eviction_trace_reader.sv
// Drains the reference-counter trace buffer of the sampler tracker: walks
// addresses 0..n-1, waits out the buffer read latency, presents each packed
// {status, trace} word on a valid/ready handshake, then pulses clear_o to
// release the tracker and done_o to signal completion.
module eviction_trace_reader
  import sampler_tracker_pkg::*;
#(
  parameter int COUNTER_BW   = 30,
  parameter int BUFFER_LIMIT = 4096,
  parameter int READ_LATENCY = 2,
  localparam int BW_BUFFER   = $clog2(BUFFER_LIMIT)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BW_BUFFER:0]    count_i,
  input  logic [COUNTER_BW-1:0] trace_i,
  input  logic [1:0]            eviction_status_i,
  output logic [BW_BUFFER-1:0]  addr_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  clear_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [BW_BUFFER:0] LIMIT    = (BW_BUFFER + 1)'(BUFFER_LIMIT);
  localparam logic [2:0]         WAIT_RLD = 3'(READ_LATENCY);

  state_e                  state_q, state_d;
  logic [BW_BUFFER:0]      n_q, n_d;
  logic [BW_BUFFER:0]      index_q, index_d;
  logic [BW_BUFFER-1:0]    addr_q, addr_d;
  logic [2:0]              wait_q, wait_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;

  logic [BW_BUFFER:0]      n_clamped;
  logic [BW_BUFFER:0]      index_next;
  logic [TRACE_WIDTH-1:0]  trace_ext;

  assign n_clamped  = (count_i > LIMIT) ? LIMIT : count_i;
  assign index_next = index_q + 1'b1;

  // Zero-extend the trace entry into the 30-bit trace field of the word.
  always_comb begin
    trace_ext                 = '0;
    trace_ext[COUNTER_BW-1:0] = trace_i;
  end

  // Next-state and datapath updates for the drain sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    n_d     = n_q;
    index_d = index_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d     = n_clamped;
          index_d = '0;
          state_d = (n_clamped == '0) ? ST_CLEAR : ST_SETADDR;
        end
      end
      ST_SETADDR: begin
        addr_d  = index_q[BW_BUFFER-1:0];
        wait_d  = WAIT_RLD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == 3'd1) begin
          data_d  = pack_word(eviction_status_i, trace_ext);
          state_d = ST_SEND;
        end
        wait_d = wait_q - 3'd1;
      end
      ST_SEND: begin
        if (ready_i) begin
          index_d = index_next;
          state_d = (index_next < n_q) ? ST_SETADDR : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      // NOTE: the data register is reset too, because data_o must read 0
      // after reset rather than a stale word from an aborted drain.
      state_q <= ST_IDLE;
      n_q     <= '0;
      index_q <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign valid_o = (state_q == ST_SEND);
  assign clear_o = (state_q == ST_CLEAR);
  assign done_o  = (state_q == ST_DONE);
  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_eviction_trace_reader.sv
// Self-checking bench for eviction_trace_reader: a latency-accurate buffer
// model feeds the reader, and a reference model of the drain (expected
// word/address queue, busy window, clear/done ordering, throughput) is
// compared against the outputs on every cycle.
module tb_eviction_trace_reader;

  localparam int COUNTER_BW   = 24;
  localparam int BUFFER_LIMIT = 4096;
  localparam int READ_LATENCY = 2;
  localparam int BW_BUFFER    = 12;

  logic                  clock_i = 1'b0;
  logic                  reset_i;
  logic                  start_i;
  logic [BW_BUFFER:0]    count_i;
  logic [COUNTER_BW-1:0] trace_i;
  logic [1:0]            eviction_status_i;
  logic [BW_BUFFER-1:0]  addr_o;
  logic [31:0]           data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  clear_o;
  logic                  busy_o;
  logic                  done_o;

  always #5 clock_i = ~clock_i;

  eviction_trace_reader #(
    .COUNTER_BW  (COUNTER_BW),
    .BUFFER_LIMIT(BUFFER_LIMIT),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .count_i          (count_i),
    .trace_i          (trace_i),
    .eviction_status_i(eviction_status_i),
    .addr_o           (addr_o),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .clear_o          (clear_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  // Tracker buffer: data for an address is readable READ_LATENCY edges after
  // addr_o changes, modelled as READ_LATENCY-1 address register stages.
  logic [COUNTER_BW-1:0] trace_mem  [BUFFER_LIMIT];
  logic [1:0]            status_mem [BUFFER_LIMIT];
  logic [BW_BUFFER-1:0]  addr_pipe  [4];
  logic [BW_BUFFER-1:0]  rd_addr;

  always @(posedge clock_i) begin
    addr_pipe[0] <= addr_o;
    for (int i = 1; i < 4; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign rd_addr           = addr_pipe[READ_LATENCY-2];
  assign trace_i           = trace_mem[rd_addr];
  assign eviction_status_i = status_mem[rd_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {status_mem[a], 30'(trace_mem[a])};
  endfunction

  // Reference model state.
  typedef struct {
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_words[$];
  bit          model_busy = 1'b0;
  bit          prev_clear = 1'b0;
  bit          hold_valid = 1'b0;
  bit          have_last  = 1'b0;
  bit          stalled    = 1'b0;
  bit          busy_next;
  logic [31:0] hold_data;
  int          cyc        = 0;
  int          last_acc   = 0;
  int          n_words;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clock_i) begin
    cyc++;
    if (reset_i) begin
      exp_q.delete();
      model_busy = 1'b0;
      prev_clear = 1'b0;
      hold_valid = 1'b0;
      have_last  = 1'b0;
      stalled    = 1'b0;
    end else begin
      busy_next = model_busy;
      check("busy", 32'(busy_o), 32'(model_busy));
      check("done_after_clear", 32'(done_o), 32'(prev_clear));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_o), 32'd0);
        end else begin
          check("addr", 32'(addr_o), 32'(exp_q[0].addr));
          if (hold_valid) check("data_stable", data_o, hold_data);
          if (ready_i) begin
            check("data", data_o, exp_q[0].word);
            got_words.push_back(data_o);
            exp_q.delete(0);
            if (have_last && !stalled)
              check("word_gap", 32'(cyc - last_acc), 32'(READ_LATENCY + 2));
            have_last  = 1'b1;
            stalled    = 1'b0;
            last_acc   = cyc;
            hold_valid = 1'b0;
          end else begin
            hold_valid = 1'b1;
            hold_data  = data_o;
            stalled    = 1'b1;
          end
        end
      end else begin
        hold_valid = 1'b0;
      end
      if (clear_o) begin
        check("clear_while_draining", 32'(model_busy), 32'd1);
        check("words_left_at_clear", 32'(exp_q.size()), 32'd0);
        busy_next = 1'b0;
      end
      if (start_i && !model_busy && !done_o) begin
        n_words = (int'(count_i) > BUFFER_LIMIT) ? BUFFER_LIMIT : int'(count_i);
        for (int a = 0; a < n_words; a++) exp_q.push_back('{addr: a, word: model_word(a)});
        busy_next = 1'b1;
        have_last = 1'b0;
        stalled   = 1'b0;
      end
      prev_clear = clear_o;
      model_busy = busy_next;
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_addr"},  32'(addr_o),  32'd0);
    check({tag, "_data"},  data_o,       32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_clear"}, 32'(clear_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o),  32'd0);
    check({tag, "_done"},  32'(done_o),  32'd0);
  endtask

  task automatic pulse_start(input int cnt);
    @(posedge clock_i); #1;
    start_i = 1'b1;
    count_i = 13'(cnt);
    @(posedge clock_i); #1;
    start_i = 1'b0;
  endtask

  // One complete drain; optionally random backpressure and a stray start
  // pulse injected at loop iteration extra_at while the drain is running.
  task automatic run_drain(input int cnt, input bit random_ready, input int extra_at);
    bit done_seen;
    int exp_words;
    done_seen = 1'b0;
    exp_words = (cnt > BUFFER_LIMIT) ? BUFFER_LIMIT : cnt;
    got_words.delete();
    ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    pulse_start(cnt);
    for (int i = 0; i < 20000 && !done_seen; i++) begin
      @(negedge clock_i);
      if (done_o) begin
        done_seen = 1'b1;
      end else begin
        @(posedge clock_i); #1;
        if (random_ready) ready_i = 1'($urandom_range(0, 1));
        if (i == extra_at) begin
          start_i = 1'b1;
          count_i = 13'd9;
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("drain_finished", 32'(done_seen), 32'd1);
    check("word_count", 32'(got_words.size()), 32'(exp_words));
  endtask

  task automatic zero_count_drain();
    got_words.delete();
    pulse_start(0);
    @(negedge clock_i);
    check("zero_clear", 32'(clear_o), 32'd1);
    check("zero_valid", 32'(valid_o), 32'd0);
    @(negedge clock_i);
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_clear_once", 32'(clear_o), 32'd0);
    check("zero_words", 32'(got_words.size()), 32'd0);
  endtask

  task automatic reset_mid_drain();
    bit found;
    int clears;
    found  = 1'b0;
    clears = 0;
    got_words.delete();
    ready_i = 1'b1;
    pulse_start(5);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock_i);
      if (valid_o && addr_o == 12'd1) begin
        found = 1'b1;
      end else begin
        @(posedge clock_i); #1;
        if (got_words.size() >= 1) ready_i = 1'b0;
      end
    end
    check("reached_word2", 32'(found), 32'd1);
    #2 reset_i = 1'b1;
    @(posedge clock_i); #1;
    check_quiet("midrst");
    @(negedge clock_i);
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    ready_i = 1'b1;
    repeat (12) begin
      @(negedge clock_i);
      if (clear_o) clears++;
    end
    check("no_clear_after_reset", 32'(clears), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    count_i = '0;
    ready_i = 1'b1;
    for (int a = 0; a < BUFFER_LIMIT; a++) begin
      trace_mem[a]  = COUNTER_BW'($urandom);
      status_mem[a] = 2'($urandom_range(0, 3));
    end
    trace_mem[0] = 24'd5; status_mem[0] = 2'b01;
    trace_mem[1] = 24'd6; status_mem[1] = 2'b00;
    trace_mem[2] = 24'd7; status_mem[2] = 2'b10;

    repeat (3) @(posedge clock_i);
    #1;
    check_quiet("reset");
    reset_i = 1'b0;

    // Known three-word drain with literal expected words.
    run_drain(3, 1'b0, -1);
    check("lit_word0", got_words[0], 32'h4000_0005);
    check("lit_word1", got_words[1], 32'h0000_0006);
    check("lit_word2", got_words[2], 32'h8000_0007);

    zero_count_drain();

    // Backpressure on four words, then assorted random drains.
    run_drain(4, 1'b1, -1);
    run_drain(4, 1'b1, -1);
    repeat (6) run_drain(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), -1);

    // Stray start while busy must not change the word count.
    run_drain(3, 1'b0, 2);

    // Reset in the middle of a drain, then a fresh drain from address 0.
    reset_mid_drain();
    run_drain(5, 1'b0, -1);

    // Oversized count is clamped to the buffer depth.
    run_drain(BUFFER_LIMIT + 1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eviction_trace_reader.md
EVICTION_TRACE_READER -- requirements
Module: eviction_trace_reader

Interface
REQ-001 Parameter COUNTER_BW, default 30, is the width of each reference-counter trace entry; legal range 1..30.
REQ-002 Parameter BUFFER_LIMIT, default 4096, is the tracker buffer depth in entries; BW_BUFFER = clog2(BUFFER_LIMIT).
REQ-003 Parameter READ_LATENCY, default 2, is the number of clocks from addr_o change to valid trace_i/eviction_status_i; legal range 1..4.
REQ-004 clock_i  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  single-cycle pulse; begins a drain when the block is idle.
REQ-007 count_i  in  BW_BUFFER+1  number of valid buffer entries, sampled at start.
REQ-008 trace_i  in  COUNTER_BW  trace read data from the tracker buffer.
REQ-009 eviction_status_i  in  2  eviction status read data from the tracker buffer.
REQ-010 addr_o  out  BW_BUFFER  buffer read address, driven into the tracker config address field.
REQ-011 data_o  out  32  packed word {eviction_status[1:0], zero-extended trace[29:0]}.
REQ-012 valid_o  out  1  data_o valid; held until accepted.
REQ-013 ready_i  in  1  host accepts data_o when valid_o && ready_i.
REQ-014 clear_o  out  1  one-cycle pulse that clears the tracker stall and address (tracker config bit 23).
REQ-015 busy_o  out  1  high from the start acceptance until the end of the CLEAR state.
REQ-016 done_o  out  1  one-cycle pulse in the cycle after clear_o.

Function
REQ-017 FSM states: IDLE, SETADDR, WAIT, SEND, CLEAR, DONE.
REQ-018 IDLE: on start_i, latch n = min(count_i, BUFFER_LIMIT), set index = 0, and go to CLEAR if n == 0, else to SETADDR; start_i outside IDLE is ignored.
REQ-019 SETADDR: drive addr_o = index, load wait counter = READ_LATENCY, and go to WAIT.
REQ-020 WAIT: decrement the counter and hold addr_o; when the counter reaches 1, register the packed word into data_o and go to SEND.
REQ-021 SEND: assert valid_o with data_o stable; on ready_i, increment index and go to SETADDR if index+1 < n, else to CLEAR.
REQ-022 Word packing: bits[31:30] = eviction_status_i, bits[29:0] = trace_i zero-extended; trace bits above COUNTER_BW are 0.
REQ-023 CLEAR: assert clear_o for exactly one cycle, then go to DONE.
REQ-024 DONE: assert done_o for one cycle, then return to IDLE.
REQ-025 Throughput: one word per READ_LATENCY+2 clocks with ready_i held high.
REQ-026 Words are emitted in ascending address order 0..n-1; no word is dropped or duplicated under arbitrary ready_i backpressure.
REQ-027 addr_o is held at the last value while in SEND, CLEAR, DONE and IDLE.

Reset
REQ-028 Reset, including reset asserted mid-drain, returns the FSM to IDLE with addr_o=0, data_o=0, and valid_o, clear_o, busy_o, done_o all 0.
REQ-029 A drain interrupted by reset does not issue clear_o.

Structure
REQ-030 State encodings and word field positions (STATUS_MSB/LSB, TRACE_WIDTH = 30) are defined in the shared sampler_tracker package.
REQ-031 The block is a single module with no sub-modules; the wait counter and FSM are inline.

Verification
REQ-032 count_i=3, memory model status {01,00,10}, trace {5,6,7}, ready_i=1 -> data_o words 0x40000005, 0x00000006, 0x80000007, then one clear_o pulse followed by one done_o pulse.
REQ-033 count_i=0 with start_i -> no valid_o; clear_o in the cycle after start, done_o in the cycle after that.
REQ-034 count_i=BUFFER_LIMIT+1 (e.g. 4097) -> exactly 4096 words, with addr_o covering 0..4095.
REQ-035 count_i=4, ready_i toggled by a random pattern -> the 4 words arrive in order and data_o is stable while valid_o && !ready_i.
REQ-036 reset_i asserted while in SEND on word 2 of 5 -> all outputs 0 next cycle, no clear_o; a new start_i drains from addr 0.
REQ-037 start_i pulsed during busy_o -> ignored; word count is unchanged.
